// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: function codes, FSM states
// and the latency-class decode used at accept and at capture.
package alu_pkg;

  localparam logic [3:0] FN_ADD = 4'b1111;
  localparam logic [3:0] FN_SUB = 4'b1110;
  localparam logic [3:0] FN_AND = 4'b1101;
  localparam logic [3:0] FN_OR  = 4'b1100;
  localparam logic [3:0] FN_MUL = 4'b0001;
  localparam logic [3:0] FN_DIV = 4'b0010;
  localparam logic [3:0] FN_SHL = 4'b1010;
  localparam logic [3:0] FN_SHR = 4'b1011;
  localparam logic [3:0] FN_ROL = 4'b1000;
  localparam logic [3:0] FN_ROR = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    LAT_SINGLE  = 2'd0,
    LAT_MUL     = 2'd1,
    LAT_DIV     = 2'd2,
    LAT_ILLEGAL = 2'd3
  } lat_class_t;

  function automatic lat_class_t lat_class_of(input logic [3:0] func);
    case (func)
      FN_ADD, FN_SUB, FN_AND, FN_OR,
      FN_SHL, FN_SHR, FN_ROL, FN_ROR: return LAT_SINGLE;
      FN_MUL:                         return LAT_MUL;
      FN_DIV:                         return LAT_DIV;
      default:                        return LAT_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Decode request, writeback response, ALU drive and R0 write signals of the
// sequencer; slave is the sequencer view, master the surrounding pipeline.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_func;
  logic [15:0] req_op_a;
  logic [15:0] req_op_b;
  logic [3:0]  req_dest;
  logic [3:0]  alu_func;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [15:0] alu_out;
  logic [15:0] alu_r0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_dest;
  logic        rsp_err;
  logic        r0_we;
  logic [15:0] r0_data;
  logic        stall;

  modport slave (
    input  req_valid, req_func, req_op_a, req_op_b, req_dest,
    input  alu_out, alu_r0, rsp_ready,
    output req_ready, alu_func, alu_in1, alu_in2,
    output rsp_valid, rsp_result, rsp_dest, rsp_err, r0_we, r0_data, stall
  );

  modport master (
    output req_valid, req_func, req_op_a, req_op_b, req_dest,
    output alu_out, alu_r0, rsp_ready,
    input  req_ready, alu_func, alu_in1, alu_in2,
    input  rsp_valid, rsp_result, rsp_dest, rsp_err, r0_we, r0_data, stall
  );
endinterface

// File: rtl/alu_lat_counter.sv
// Loadable 4-bit down-counter with zero flag; times the ALU hold period.
module alu_lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle issue sequencer in front of the execute-stage ALU: holds operands,
// waits a per-class latency, returns the result and drives the R0 side write.
// Defining ALU_SEQ_PERF_EN adds the perf_ops / perf_stall counter outputs.
//
// state   | meaning
// IDLE    | no operation held, ready for decode
// EXEC    | operands held on the ALU, latency counter running
// RESP    | result presented to writeback until consumed
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]    perf_ops,
  output logic [31:0]    perf_stall
`endif
);

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic        w_req_ready;
  logic        w_rsp_valid;
  logic        w_stall;
  logic        w_accept;
  logic        w_capture;
  logic        w_cnt_zero;
  logic [3:0]  w_load_val;
  lat_class_t  w_req_class;
  lat_class_t  w_hold_class;

  logic [3:0]  r_func;
  logic [15:0] r_op_a;
  logic [15:0] r_op_b;
  logic [3:0]  r_dest;
  logic [15:0] r_rsp_result;
  logic [3:0]  r_rsp_dest;
  logic        r_rsp_err;
  logic        r_r0_we;
  logic [15:0] r_r0_data;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.req_valid) w_state_nxt = ST_EXEC;
      ST_EXEC: if (w_cnt_zero) w_state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_state_nxt = bus.req_valid ? ST_EXEC : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: w_req_ready = 1'b1;
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        w_req_ready = bus.rsp_ready;
      end
      default: ;
    endcase
  end

  assign w_stall      = bus.req_valid & ~w_req_ready;
  assign w_accept     = bus.req_valid & w_req_ready;
  assign w_capture    = (r_state == ST_EXEC) & w_cnt_zero;
  assign w_hold_class = lat_class_of(r_func);

  // A zero divisor completes like a single-cycle op; the ALU is never waited on.
  always_comb begin
    w_req_class = lat_class_of(bus.req_func);
    case (w_req_class)
      LAT_MUL: w_load_val = 4'(MUL_LAT - 1);
      LAT_DIV: w_load_val = (bus.req_op_b == 16'd0) ? 4'd0 : 4'(DIV_LAT - 1);
      default: w_load_val = 4'd0;
    endcase
  end

  alu_lat_counter u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .i_dec      (r_state == ST_EXEC),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_func       <= 4'd0;
      r_op_a       <= 16'd0;
      r_op_b       <= 16'd0;
      r_dest       <= 4'd0;
      r_rsp_result <= 16'd0;
      r_rsp_dest   <= 4'd0;
      r_rsp_err    <= 1'b0;
      r_r0_we      <= 1'b0;
      r_r0_data    <= 16'd0;
    end else begin
      r_r0_we <= 1'b0;
      if (w_accept) begin
        r_func <= bus.req_func;
        r_op_a <= bus.req_op_a;
        r_op_b <= bus.req_op_b;
        r_dest <= bus.req_dest;
      end
      if (w_capture) begin
        r_rsp_dest <= r_dest;
        case (w_hold_class)
          LAT_ILLEGAL: begin
            r_rsp_result <= 16'd0;
            r_rsp_err    <= 1'b1;
          end
          LAT_DIV: begin
            r_r0_we <= 1'b1;
            if (r_op_b == 16'd0) begin
              r_rsp_result <= 16'hFFFF;
              r_rsp_err    <= 1'b1;
              r_r0_data    <= r_op_a;
            end else begin
              r_rsp_result <= bus.alu_out;
              r_rsp_err    <= 1'b0;
              r_r0_data    <= bus.alu_r0;
            end
          end
          LAT_MUL: begin
            r_rsp_result <= bus.alu_out;
            r_rsp_err    <= 1'b0;
            r_r0_we      <= 1'b1;
            r_r0_data    <= bus.alu_r0;
          end
          default: begin
            r_rsp_result <= bus.alu_out;
            r_rsp_err    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.stall      = w_stall;
  assign bus.alu_func   = r_func;
  assign bus.alu_in1    = r_op_a;
  assign bus.alu_in2    = r_op_b;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_dest   = r_rsp_dest;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.r0_we      = r_r0_we;
  assign bus.r0_data    = r_r0_data;

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_ops   <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (w_rsp_valid && bus.rsp_ready) r_perf_ops <= r_perf_ops + 32'd1;
      if (w_stall) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_ops   = r_perf_ops;
  assign perf_stall = r_perf_stall;
`endif

endmodule
